// File: rtl/io_ddr_link_seq_if.sv
// rtl/io_ddr_link_seq_if.sv - control, DDR-side and user-side signal bundle for the link sequencer
interface io_ddr_link_seq_if;
  logic       start;
  logic       stop;
  logic       ddr_rst;
  logic       ddr_en;
  logic [1:0] tx_data;
  logic [1:0] rx_data;
  logic [1:0] user_tx;
  logic [1:0] user_rx;
  logic       user_valid;
  logic       busy;
  logic       ready;
  logic       fail;
  logic [7:0] err_cnt;
  logic [3:0] retry_cnt;

  // Sequencer side
  modport slave (
    input  start, stop, rx_data, user_tx,
    output ddr_rst, ddr_en, tx_data, user_rx, user_valid,
           busy, ready, fail, err_cnt, retry_cnt
  );

  // Controller / loopback side
  modport master (
    output start, stop, rx_data, user_tx,
    input  ddr_rst, ddr_en, tx_data, user_rx, user_valid,
           busy, ready, fail, err_cnt, retry_cnt
  );
endinterface

// File: rtl/io_ddr_link_seq.sv
// rtl/io_ddr_link_seq.sv - DDR link bring-up, loopback training and datapath handover sequencer
module io_ddr_link_seq #(
  parameter int         RST_CYCLES = 8,
  parameter int         LOOP_LAT   = 2,
  parameter int         TRAIN_LEN  = 16,
  parameter logic [1:0] PATTERN    = 2'b10,
  parameter int         MAX_RETRY  = 3
) (
  input logic               clk,
  input logic               reset,
  io_ddr_link_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE, RESET, WARMUP, TRAIN, READY, FAIL
  } state_t;

  localparam logic [7:0] RST_LAST   = 8'(RST_CYCLES - 1);
  localparam logic [7:0] WARM_LAST  = 8'(LOOP_LAT - 1);
  localparam logic [7:0] TRAIN_LAST = 8'(TRAIN_LEN - 1);
  localparam logic [3:0] RETRY_MAX  = 4'(MAX_RETRY);

  state_t     state_q;
  logic [7:0] cnt_q;
  logic [1:0] sr_q [LOOP_LAT];
  logic       ddr_rst_q;
  logic       ddr_en_q;
  logic [1:0] tx_data_q;
  logic [1:0] user_rx_q;
  logic       user_valid_q;
  logic       busy_q;
  logic       ready_q;
  logic       fail_q;
  logic [7:0] err_cnt_q;
  logic [3:0] retry_cnt_q;

  logic       mismatch;
  logic [7:0] err_nxt;
  logic [3:0] retry_nxt;

  // The oldest word in the expected-pattern line lines up with the rx word arriving now
  assign mismatch  = (bus.rx_data != sr_q[LOOP_LAT-1]);
  assign err_nxt   = (mismatch && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
  assign retry_nxt = retry_cnt_q + 4'd1;

  // Sequencer FSM; outputs are registered alongside the state they belong to
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      for (int i = 0; i < LOOP_LAT; i++) sr_q[i] <= '0;
      ddr_rst_q    <= 1'b1;
      ddr_en_q     <= 1'b0;
      tx_data_q    <= '0;
      user_rx_q    <= '0;
      user_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      ready_q      <= 1'b0;
      fail_q       <= 1'b0;
      err_cnt_q    <= '0;
      retry_cnt_q  <= '0;
    end else begin
      // Expected line always tracks what was transmitted; only TRAIN looks at it
      sr_q[0] <= tx_data_q;
      for (int i = 1; i < LOOP_LAT; i++) sr_q[i] <= sr_q[i-1];

      // Idle-style outputs unless the branch below says otherwise
      ddr_rst_q    <= 1'b1;
      ddr_en_q     <= 1'b0;
      tx_data_q    <= '0;
      user_rx_q    <= '0;
      user_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      ready_q      <= 1'b0;
      fail_q       <= 1'b0;

      if (bus.stop) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.start) begin
              state_q     <= RESET;
              cnt_q       <= '0;
              err_cnt_q   <= '0;
              retry_cnt_q <= '0;
              busy_q      <= 1'b1;
            end
          end

          RESET: begin
            busy_q <= 1'b1;
            if (cnt_q == RST_LAST) begin
              state_q   <= WARMUP;
              cnt_q     <= '0;
              ddr_rst_q <= 1'b0;
              ddr_en_q  <= 1'b1;
              tx_data_q <= PATTERN;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end

          WARMUP: begin
            busy_q    <= 1'b1;
            ddr_rst_q <= 1'b0;
            ddr_en_q  <= 1'b1;
            tx_data_q <= ~tx_data_q;
            if (cnt_q == WARM_LAST) begin
              state_q   <= TRAIN;
              cnt_q     <= '0;
              err_cnt_q <= '0;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end

          TRAIN: begin
            err_cnt_q <= err_nxt;
            if (cnt_q == TRAIN_LAST) begin
              cnt_q <= '0;
              if (err_nxt == 8'd0) begin
                state_q      <= READY;
                ddr_rst_q    <= 1'b0;
                ddr_en_q     <= 1'b1;
                tx_data_q    <= bus.user_tx;
                user_rx_q    <= bus.rx_data;
                user_valid_q <= 1'b1;
                ready_q      <= 1'b1;
              end else begin
                retry_cnt_q <= retry_nxt;
                if (retry_nxt == RETRY_MAX) begin
                  state_q <= FAIL;
                  fail_q  <= 1'b1;
                end else begin
                  state_q <= RESET;
                  busy_q  <= 1'b1;
                end
              end
            end else begin
              cnt_q     <= cnt_q + 8'd1;
              busy_q    <= 1'b1;
              ddr_rst_q <= 1'b0;
              ddr_en_q  <= 1'b1;
              tx_data_q <= ~tx_data_q;
            end
          end

          READY: begin
            ddr_rst_q    <= 1'b0;
            ddr_en_q     <= 1'b1;
            tx_data_q    <= bus.user_tx;
            user_rx_q    <= bus.rx_data;
            user_valid_q <= 1'b1;
            ready_q      <= 1'b1;
          end

          FAIL: begin
            if (bus.start) begin
              state_q     <= RESET;
              cnt_q       <= '0;
              err_cnt_q   <= '0;
              retry_cnt_q <= '0;
              busy_q      <= 1'b1;
            end else begin
              fail_q <= 1'b1;
            end
          end

          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.ddr_rst    = ddr_rst_q;
  assign bus.ddr_en     = ddr_en_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.user_rx    = user_rx_q;
  assign bus.user_valid = user_valid_q;
  assign bus.busy       = busy_q;
  assign bus.ready      = ready_q;
  assign bus.fail       = fail_q;
  assign bus.err_cnt    = err_cnt_q;
  assign bus.retry_cnt  = retry_cnt_q;

endmodule

// File: tb/tb_io_ddr_link_seq.sv
// tb/tb_io_ddr_link_seq.sv - scoreboard bench for the DDR link sequencer
module tb_io_ddr_link_seq;

  logic clk;
  logic reset;

  io_ddr_link_seq_if bus ();

  io_ddr_link_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] err;
    logic [3:0] retry;
    logic       rdy;
    logic       fl;
  } attempt_t;

  typedef struct {
    logic [1:0] tx;
    logic [1:0] rx;
  } word_t;

  attempt_t sbq [$];
  word_t    wq  [$];

  int tests_run = 0;
  int tests_failed = 0;

  // Loopback model controls
  int ncyc = 0;
  int lat = 2;
  logic stuck = 1'b0;
  int corrupt_cyc = -1;
  logic [1:0] hist [4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    tick();
  endtask

  // Loopback: rx carries tx delayed by lat cycles, optionally stuck or corrupted once
  initial begin
    for (int i = 0; i < 4; i++) hist[i] = 2'b00;
    bus.rx_data = 2'b00;
    forever begin
      @(negedge clk);
      ncyc++;
      for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = bus.tx_data;
      if (stuck) bus.rx_data = 2'b00;
      else if (ncyc == corrupt_cyc) bus.rx_data = hist[lat] ^ 2'b11;
      else bus.rx_data = hist[lat];
    end
  end

  // Pops one scoreboard entry per attempt outcome as the DUT reports it
  task automatic collect(input int n);
    logic [3:0] last;
    int wait_cyc;
    attempt_t e;
    last = bus.retry_cnt;
    for (int k = 0; k < n; k++) begin
      wait_cyc = 0;
      while (bus.retry_cnt == last && !bus.ready && !bus.fail && wait_cyc < 200) begin
        tick();
        wait_cyc++;
      end
      if (wait_cyc >= 200) begin
        check("attempt_timeout", 32'd1, 32'd0);
        return;
      end
      if (sbq.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
        return;
      end
      e = sbq.pop_front();
      check("att_err_cnt", 32'(bus.err_cnt), 32'(e.err));
      check("att_retry_cnt", 32'(bus.retry_cnt), 32'(e.retry));
      check("att_ready", 32'(bus.ready), 32'(e.rdy));
      check("att_fail", 32'(bus.fail), 32'(e.fl));
      if (e.fl) begin
        check("fail_ddr_rst", 32'(bus.ddr_rst), 32'd1);
        check("fail_ddr_en", 32'(bus.ddr_en), 32'd0);
      end
      last = bus.retry_cnt;
    end
  endtask

  task automatic push_att(input logic [7:0] err, input logic [3:0] retry, input logic rdy, input logic fl);
    attempt_t e;
    e.err = err;
    e.retry = retry;
    e.rdy = rdy;
    e.fl = fl;
    sbq.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_n;
    int rst_n_cnt;
    int en_n;
    logic [1:0] seq [3];
    word_t w;
    seq[0] = 2'b01;
    seq[1] = 2'b10;
    seq[2] = 2'b11;

    reset = 1'b0;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.user_tx = 2'b00;
    tick();
    tick();
    check("rst_ddr_rst", 32'(bus.ddr_rst), 32'd1);
    check("rst_ddr_en", 32'(bus.ddr_en), 32'd0);
    check("rst_tx_data", 32'(bus.tx_data), 32'd0);
    check("rst_user_rx", 32'(bus.user_rx), 32'd0);
    check("rst_flags", 32'({bus.user_valid, bus.busy, bus.ready, bus.fail}), 32'd0);
    check("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
    check("rst_retry_cnt", 32'(bus.retry_cnt), 32'd0);
    reset = 1'b1;
    tick();

    // Ideal loopback: bring-up timing and READY
    lat = 2;
    pulse_start();
    busy_n = 0;
    rst_n_cnt = 0;
    en_n = 0;
    while (bus.busy && busy_n < 200) begin
      busy_n++;
      if (bus.ddr_rst) rst_n_cnt++;
      if (bus.ddr_en) en_n++;
      tick();
    end
    check("busy_cycles", 32'(busy_n), 32'd26);
    check("reset_cycles", 32'(rst_n_cnt), 32'd8);
    check("enabled_cycles", 32'(en_n), 32'd18);
    check("ideal_ready", 32'(bus.ready), 32'd1);
    check("ideal_err_cnt", 32'(bus.err_cnt), 32'd0);
    check("ideal_retry_cnt", 32'(bus.retry_cnt), 32'd0);

    // READY datapath: tx follows user_tx, user_rx follows rx, both one cycle late
    for (int i = 0; i < 4; i++) begin
      if (wq.size() > 0) begin
        w = wq.pop_front();
        check("ready_tx_data", 32'(bus.tx_data), 32'(w.tx));
        check("ready_user_rx", 32'(bus.user_rx), 32'(w.rx));
        check("ready_user_valid", 32'(bus.user_valid), 32'd1);
      end
      if (i < 3) begin
        bus.user_tx = seq[i];
        w.tx = seq[i];
        w.rx = bus.rx_data;
        wq.push_back(w);
        tick();
      end
    end
    pulse_stop();
    check("stop_ready", 32'(bus.ready), 32'd0);
    check("stop_ddr_rst", 32'(bus.ddr_rst), 32'd1);

    // Loopback stuck at zero: three failing attempts then FAIL
    stuck = 1'b1;
    push_att(8'd16, 4'd1, 1'b0, 1'b0);
    push_att(8'd16, 4'd2, 1'b0, 1'b0);
    push_att(8'd16, 4'd3, 1'b0, 1'b1);
    pulse_start();
    collect(3);

    // Restart from FAIL with a clean loopback
    stuck = 1'b0;
    push_att(8'd0, 4'd0, 1'b1, 1'b0);
    pulse_start();
    check("restart_retry_cnt", 32'(bus.retry_cnt), 32'd0);
    check("restart_busy", 32'(bus.busy), 32'd1);
    collect(1);
    pulse_stop();

    // Wrong loopback latency: every compare misses
    lat = 3;
    push_att(8'd16, 4'd1, 1'b0, 1'b0);
    push_att(8'd16, 4'd2, 1'b0, 1'b0);
    push_att(8'd16, 4'd3, 1'b0, 1'b1);
    pulse_start();
    collect(3);
    lat = 2;

    // One corrupted word in the first attempt only
    push_att(8'd1, 4'd1, 1'b0, 1'b0);
    push_att(8'd0, 4'd1, 1'b1, 1'b0);
    pulse_start();
    corrupt_cyc = ncyc + 15;
    collect(2);
    corrupt_cyc = -1;
    pulse_stop();

    // Stop and start together mid-TRAIN: stop wins
    pulse_start();
    for (int i = 0; i < 14; i++) tick();
    bus.start = 1'b1;
    bus.stop = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.stop = 1'b0;
    check("ss_busy", 32'(bus.busy), 32'd0);
    check("ss_ddr", 32'({bus.ddr_rst, bus.ddr_en}), 32'b10);
    check("ss_tx_data", 32'(bus.tx_data), 32'd0);
    tick();
    tick();
    check("ss_stays_idle", 32'(bus.busy), 32'd0);

    // Asynchronous reset in WARMUP
    pulse_start();
    for (int i = 0; i < 8; i++) tick();
    check("warm_ddr_en", 32'(bus.ddr_en), 32'd1);
    reset = 1'b0;
    #1;
    check("areset_ddr", 32'({bus.ddr_rst, bus.ddr_en}), 32'b10);
    check("areset_tx_data", 32'(bus.tx_data), 32'd0);
    check("areset_busy", 32'(bus.busy), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    tick();
    check("post_reset_idle", 32'({bus.busy, bus.ready, bus.fail}), 32'd0);

    check("sb_empty", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/io_ddr_link_seq.md
Name: io_ddr_link_seq

Overview:
- Bring-up and training sequencer for a DDR I/O link built from I_DDR/O_DDR pairs sharing one clock, reset and enable.
- Sequences DDR reset, enables the primitives, and runs a loopback pattern check before granting the datapath to user logic.
- Sits between the user datapath and the DDR primitives. It drives their R/E/D inputs and consumes I_DDR Q.

Parameters:
RST_CYCLES, 8, cycles ddr_rst is held high in RESET (1..255)
LOOP_LAT, 2, loopback latency in cycles from tx_data to matching rx_data (1..8)
TRAIN_LEN, 16, compare cycles per training attempt (1..255)
PATTERN, 2'b10, training word; alternates with its bitwise inverse each cycle
MAX_RETRY, 3, failed attempts allowed before FAIL (1..15)

Ports:
clk  in  1  fabric clock (post CLK_BUF)
reset  in  1  asynchronous, active-low reset
start  in  1  single-cycle pulse; begins bring-up from IDLE or FAIL
stop  in  1  returns to IDLE from any state
ddr_rst  out  1  to R of I_DDR/O_DDR, active-high
ddr_en  out  1  to E of I_DDR/O_DDR
tx_data  out  2  to O_DDR D
rx_data  in  2  from I_DDR Q
user_tx  in  2  user transmit word, forwarded in READY
user_rx  out  2  rx_data forwarded in READY, else 0
user_valid  out  1  high in READY
busy  out  1  high in RESET, WARMUP, TRAIN
ready  out  1  high in READY
fail  out  1  high in FAIL
err_cnt  out  8  mismatches in the current or last attempt; saturates at 255
retry_cnt  out  4  failed attempts since last start

Behaviour:
- Reset (reset=0, async):
  - State goes to IDLE.
  - Outputs: ddr_rst=1, ddr_en=0, tx_data=0, user_rx=0.
  - user_valid, busy, ready and fail are 0.
  - err_cnt=0, retry_cnt=0.
  - All counters and the expected-pattern shift register are cleared.
- Outputs are registered and change one cycle after the state transition that causes them.
- States: IDLE, RESET, WARMUP, TRAIN, READY, FAIL.
- IDLE:
  - ddr_rst=1, ddr_en=0, tx_data=0.
  - start -> RESET. Clear err_cnt and retry_cnt.
- RESET:
  - ddr_rst=1, ddr_en=0.
  - After exactly RST_CYCLES cycles -> WARMUP.
- WARMUP:
  - ddr_rst=0, ddr_en=1.
  - tx_data starts at PATTERN and toggles to ~PATTERN every cycle.
  - Each tx_data word is pushed into a LOOP_LAT-deep expected shift register.
  - After LOOP_LAT cycles -> TRAIN. The tx phase is not restarted.
- TRAIN:
  - tx_data keeps alternating.
  - Each cycle, rx_data is compared with the shift-register output.
  - A mismatch increments err_cnt, saturating at 255.
  - After TRAIN_LEN compares:
    - err_cnt==0 -> READY.
    - Otherwise retry_cnt+1. If the new value equals MAX_RETRY -> FAIL, else -> RESET.
  - err_cnt is cleared on entry to TRAIN. It keeps its value in READY and FAIL.
- READY:
  - ddr_rst=0, ddr_en=1.
  - tx_data=user_tx, registered with 1 cycle latency.
  - user_rx=rx_data, registered; user_valid=1.
  - start is ignored. State is held until stop or reset.
- FAIL:
  - ddr_rst=1, ddr_en=0, fail=1.
  - start -> RESET, clearing retry_cnt and err_cnt.
- stop:
  - In any non-IDLE state -> IDLE next cycle. IDLE output values apply.
  - retry_cnt and err_cnt keep their values until the next start.
- Simultaneous start and stop: stop wins.
- start in RESET, WARMUP or TRAIN is ignored.
- Reset asserted mid-training aborts immediately to IDLE with reset values. There is no partial-attempt state.

Test Plan:
- Reset, then start with ideal loopback (rx = tx delayed 2 cycles):
  - ddr_rst high 8 cycles after RESET entry.
  - WARMUP lasts 2 cycles, then TRAIN lasts 16 cycles.
  - ready=1, err_cnt=0, retry_cnt=0.
- Loopback stuck at 2'b00:
  - Each attempt gives err_cnt=16.
  - retry_cnt steps 1, 2, 3, then fail=1 with ddr_rst=1 and ddr_en=0.
  - A following start restarts with retry_cnt=0.
- Loopback delay 3 instead of 2: every compare mismatches (alternating pattern), err_cnt=16 per attempt, ends in FAIL.
- Single corrupted rx word in attempt 1, clean in attempt 2: retry_cnt=1, err_cnt=1 then 0, then READY.
- In READY, user_tx sequence 01,10,11: tx_data follows 1 cycle later; user_rx equals rx_data delayed 1 cycle; user_valid=1.
- stop and start in the same cycle mid-TRAIN -> IDLE. Reset asserted mid-WARMUP -> all outputs at reset values in the same cycle (async).
